// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift-register blocks (master and slave).
package spi_pkg;

   localparam int SPI_DW = 8;

   // cpha values as seen by the edge-select helpers
   localparam logic SPI_CPHA_LEADING  = 1'b0;
   localparam logic SPI_CPHA_TRAILING = 1'b1;

   typedef enum logic {
      IDLE,
      ACTIVE
   } spi_state_e;

   function automatic logic spi_sample_edge(input logic cpha, input logic lead, input logic trail);
      return (cpha == SPI_CPHA_TRAILING) ? trail : lead;
   endfunction

   function automatic logic spi_shift_edge(input logic cpha, input logic lead, input logic trail);
      return (cpha == SPI_CPHA_LEADING) ? trail : lead;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous pin with rise/fall detection on
// the synchronized level. init_val is the level assumed while in reset, so a
// pin that idles at that level produces no edge when reset is released.
module spi_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic init_val,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;

   // Synchronizer chain plus one history flop for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {STAGES{init_val}};
         hist_q <= init_val;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], async_in};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign sync_out = sync_q[STAGES-1];
   assign rise     = sync_out & ~hist_q;
   assign fall     = ~sync_out & hist_q;

endmodule

// File: rtl/spi_slave_shift.sv
// SPI slave shift register: receives mosi bytes and drives miso from a
// single-entry TX buffer, everything sampled into the PCLK domain.
module spi_slave_shift
   import spi_pkg::*;
#(
   parameter int DW          = SPI_DW,
   parameter int SYNC_STAGES = 2
) (
   input  logic          PCLK,
   input  logic          PRESET,
   input  logic          cpol,
   input  logic          cpha,
   input  logic          lsbfe,
   input  logic          sclk,
   input  logic          ss,
   input  logic          mosi,
   output logic          miso,
   output logic          miso_oe,
   input  logic [DW-1:0] tx_data,
   input  logic          tx_load,
   output logic          tx_ready,
   output logic [DW-1:0] rx_data,
   output logic          rx_valid,
   input  logic          rx_ack,
   output logic          rx_overrun,
   input  logic          ovr_clr
);

   localparam int CW = $clog2(DW);

   spi_state_e state, state_next;

   logic                   sclk_s, sclk_rise, sclk_fall;
   logic                   ss_s, ss_rise, ss_fall;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   mosi_s;
   logic [SYNC_STAGES-1:0] flush_q;
   logic                   ss_armed;

   logic                   cfg_cpol, cfg_cpha, cfg_lsbfe;
   logic [DW-1:0]          tx_shift, rx_shift, rx_next, tx_buf, tx_fill;
   logic [CW-1:0]          bit_cnt;
   logic                   suppress, tx_full, rx_pending;

   logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
   logic frame_start, frame_abort, in_frame, do_sample, do_shift, byte_done;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk      (PCLK),
      .rst      (PRESET),
      .init_val (cpol),
      .async_in (sclk),
      .sync_out (sclk_s),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
      .clk      (PCLK),
      .rst      (PRESET),
      .init_val (1'b1),
      .async_in (ss),
      .sync_out (ss_s),
      .rise     (ss_rise),
      .fall     (ss_fall)
   );

   // mosi only needs the synchronizer, kept the same depth as sclk so data and clock stay aligned
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) mosi_q <= '0;
      else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
   end
   assign mosi_s = mosi_q[SYNC_STAGES-1];

   // After reset the ss synchronizer holds its idle value until the pad has propagated; a frame may only start after ss is really seen high
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         flush_q  <= '0;
         ss_armed <= 1'b0;
      end else begin
         flush_q <= {flush_q[SYNC_STAGES-2:0], 1'b1};
         if (flush_q[SYNC_STAGES-1] && ss_s) ss_armed <= 1'b1;
      end
   end

   assign sclk_edge   = sclk_rise | sclk_fall;
   assign lead_edge   = sclk_edge & (sclk_s != cfg_cpol);
   assign trail_edge  = sclk_edge & (sclk_s == cfg_cpol);
   assign sample_edge = spi_sample_edge(cfg_cpha, lead_edge, trail_edge);
   assign shift_edge  = spi_shift_edge(cfg_cpha, lead_edge, trail_edge);

   assign frame_start = (state == IDLE) && ss_fall && ss_armed;
   assign frame_abort = (state == ACTIVE) && ss_rise;
   assign in_frame    = (state == ACTIVE) && !ss_rise;
   assign do_sample   = in_frame && sample_edge;
   assign do_shift    = in_frame && shift_edge;
   assign byte_done   = do_sample && (bit_cnt == CW'(DW - 1));

   assign tx_fill  = tx_full ? tx_buf : '0;
   assign rx_next  = cfg_lsbfe ? {mosi_s, rx_shift[DW-1:1]} : {rx_shift[DW-2:0], mosi_s};
   assign tx_ready = ~tx_full;

   // State register
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) state <= IDLE;
      else        state <= state_next;
   end

   // Next state and pad outputs; miso is only driven while the frame is active
   always_comb begin
      state_next = state;
      miso_oe    = 1'b0;
      miso       = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) state_next = ACTIVE;
         end
         ACTIVE: begin
            miso_oe = 1'b1;
            miso    = cfg_lsbfe ? tx_shift[0] : tx_shift[DW-1];
            if (ss_rise) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Frame datapath: latch config at frame start, sample/shift on sclk edges, reload TX after each byte
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         cfg_cpol  <= 1'b0;
         cfg_cpha  <= 1'b0;
         cfg_lsbfe <= 1'b0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         bit_cnt   <= '0;
         suppress  <= 1'b0;
      end else if (frame_start) begin
         cfg_cpol  <= cpol;
         cfg_cpha  <= cpha;
         cfg_lsbfe <= lsbfe;
         tx_shift  <= tx_fill;
         rx_shift  <= '0;
         bit_cnt   <= '0;
         suppress  <= cpha;
      end else if (frame_abort) begin
         rx_shift <= '0;
         bit_cnt  <= '0;
         suppress <= 1'b0;
      end else if (do_sample) begin
         rx_shift <= rx_next;
         if (byte_done) begin
            bit_cnt  <= '0;
            tx_shift <= tx_fill;
            suppress <= 1'b1;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end else if (do_shift) begin
         if (suppress) suppress <= 1'b0;
         else          tx_shift <= cfg_lsbfe ? (tx_shift >> 1) : (tx_shift << 1);
      end
   end

   // Receive handshake: rx_valid pulse, pending flag and sticky overrun
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rx_pending <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         rx_valid <= byte_done;
         if (byte_done) rx_data <= rx_next;
         if (byte_done)   rx_pending <= 1'b1;
         else if (rx_ack) rx_pending <= 1'b0;
         if (byte_done && rx_pending && !rx_ack) rx_overrun <= 1'b1;
         else if (ovr_clr)                       rx_overrun <= 1'b0;
      end
   end

   // TX buffer: a load is taken only while empty; consumption sees the state before any coincident load
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         tx_buf  <= '0;
         tx_full <= 1'b0;
      end else if (tx_load && !tx_full) begin
         tx_buf  <= tx_data;
         tx_full <= 1'b1;
      end else if (frame_start || byte_done) begin
         tx_full <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_slave_shift.sv
// Directed bench for spi_slave_shift: the bench acts as SPI master and
// host, running a table of single-byte frames plus multi-cycle sequences.
module tb_spi_slave_shift;

   localparam int PERIOD      = 10;
   localparam int HALF        = 60;
   localparam int SYNC_STAGES = 2;

   logic       PCLK, PRESET, cpol, cpha, lsbfe, sclk, ss, mosi;
   logic       miso, miso_oe, tx_load, tx_ready, rx_valid, rx_ack, rx_overrun, ovr_clr;
   logic [7:0] tx_data, rx_data;

   int checks    = 0;
   int failures  = 0;
   int valid_cnt = 0;

   typedef struct {
      logic       cpol;
      logic       cpha;
      logic       lsbfe;
      logic       load;
      logic [7:0] tx;
      logic [7:0] mosi_byte;
      logic [7:0] exp_miso;
      logic [7:0] exp_rx;
   } vec_t;

   vec_t vecs[5];

   spi_slave_shift #(.DW(8), .SYNC_STAGES(SYNC_STAGES)) dut (
      .PCLK       (PCLK),
      .PRESET     (PRESET),
      .cpol       (cpol),
      .cpha       (cpha),
      .lsbfe      (lsbfe),
      .sclk       (sclk),
      .ss         (ss),
      .mosi       (mosi),
      .miso       (miso),
      .miso_oe    (miso_oe),
      .tx_data    (tx_data),
      .tx_load    (tx_load),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ack     (rx_ack),
      .rx_overrun (rx_overrun),
      .ovr_clr    (ovr_clr)
   );

   // Free-running system clock, negedges fall on multiples of PERIOD
   initial begin
      PCLK = 1'b0;
      forever #(PERIOD / 2) PCLK = ~PCLK;
   end

   // Count every cycle rx_valid is high, so a stretched pulse shows up as an extra count
   always @(negedge PCLK) begin
      if (rx_valid) valid_cnt++;
   end

   // Guard against a stuck run
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic pulseLoad(input logic [7:0] d);
      tx_data = d;
      tx_load = 1'b1;
      #PERIOD;
      tx_load = 1'b0;
   endtask

   task automatic ackRx();
      rx_ack = 1'b1;
      #PERIOD;
      rx_ack = 1'b0;
   endtask

   task automatic setMode(input logic m_cpol, input logic m_cpha, input logic m_lsb);
      cpol  = m_cpol;
      cpha  = m_cpha;
      lsbfe = m_lsb;
      sclk  = m_cpol;
      ss    = 1'b1;
      #100;
   endtask

   // Master side of nbits of a transfer; optionally pulses tx_load after the fourth bit
   task automatic spiXfer(input logic m_cpol, input logic m_cpha, input logic m_lsb,
                          input logic [7:0] mo, input int nbits,
                          input logic mid_load, input logic [7:0] mid_data,
                          output logic [7:0] mi);
      int idx;
      mi = 8'h00;
      for (int k = 0; k < nbits; k++) begin
         idx = m_lsb ? k : 7 - k;
         if (!m_cpha) begin
            mosi = mo[idx];
            #HALF;
            sclk = ~m_cpol;
            mi[idx] = miso;
            #HALF;
            sclk = m_cpol;
         end else begin
            sclk = ~m_cpol;
            mosi = mo[idx];
            #HALF;
            sclk = m_cpol;
            mi[idx] = miso;
            #HALF;
         end
         if (mid_load && k == 3) pulseLoad(mid_data);
      end
   endtask

   // One complete single-byte frame with its result checks and a host acknowledge
   task automatic runFrame(input vec_t v, input string tag);
      logic [7:0] got;
      int         cnt0;
      ss = 1'b0;
      #100;
      checkOutput({tag, "_tx_ready_start"}, tx_ready, 1);
      checkOutput({tag, "_miso_oe"}, miso_oe, 1);
      cnt0 = valid_cnt;
      spiXfer(v.cpol, v.cpha, v.lsbfe, v.mosi_byte, 8, 1'b0, 8'h00, got);
      #HALF;
      ss = 1'b1;
      #100;
      checkOutput({tag, "_miso_byte"}, got, v.exp_miso);
      checkOutput({tag, "_rx_data"}, rx_data, v.exp_rx);
      checkOutput({tag, "_rx_valid_cnt"}, valid_cnt - cnt0, 1);
      checkOutput({tag, "_overrun"}, rx_overrun, 0);
      checkOutput({tag, "_oe_idle"}, miso_oe, 0);
      ackRx();
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("v%0d", idx);
      setMode(v.cpol, v.cpha, v.lsbfe);
      if (v.load) pulseLoad(v.tx);
      checkOutput({tag, "_tx_ready_pre"}, tx_ready, v.load ? 0 : 1);
      runFrame(v, tag);
   endtask

   initial begin
      logic [7:0] got1, got2;
      int         cnt0;
      vec_t       v;

      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
      vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 8'h5A, 8'h81, 8'h5A};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h96, 8'h0F, 8'h96, 8'h0F};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h3E, 8'hC7, 8'h3E, 8'hC7};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5E, 8'h00, 8'h5E};

      cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
      sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
      tx_data = 8'h00; tx_load = 1'b0; rx_ack = 1'b0; ovr_clr = 1'b0;
      PRESET = 1'b1;
      #PERIOD;
      checkOutput("rst_miso", miso, 0);
      checkOutput("rst_miso_oe", miso_oe, 0);
      checkOutput("rst_tx_ready", tx_ready, 1);
      checkOutput("rst_rx_data", rx_data, 0);
      checkOutput("rst_rx_valid", rx_valid, 0);
      checkOutput("rst_overrun", rx_overrun, 0);
      #PERIOD;
      PRESET = 1'b0;
      #50;

      // Table of single-byte frames across all four modes plus a TX underrun
      for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

      // Back-to-back bytes under one ss low, refilling the buffer mid-byte, no acknowledge
      $display("[TB] back-to-back frame");
      setMode(1'b0, 1'b0, 1'b0);
      pulseLoad(8'h5C);
      ss = 1'b0;
      #100;
      cnt0 = valid_cnt;
      spiXfer(1'b0, 1'b0, 1'b0, 8'h11, 8, 1'b1, 8'hEE, got1);
      spiXfer(1'b0, 1'b0, 1'b0, 8'h22, 8, 1'b0, 8'h00, got2);
      #HALF;
      ss = 1'b1;
      #100;
      checkOutput("b2b_miso_first", got1, 8'h5C);
      checkOutput("b2b_miso_second", got2, 8'hEE);
      checkOutput("b2b_rx_valid_cnt", valid_cnt - cnt0, 2);
      checkOutput("b2b_rx_data", rx_data, 8'h22);
      checkOutput("b2b_overrun_set", rx_overrun, 1);
      checkOutput("b2b_tx_ready", tx_ready, 1);
      ovr_clr = 1'b1;
      #PERIOD;
      ovr_clr = 1'b0;
      #PERIOD;
      checkOutput("b2b_overrun_clr", rx_overrun, 0);
      ackRx();

      // Abort after five bits, then a clean frame
      $display("[TB] abort frame");
      setMode(1'b0, 1'b0, 1'b0);
      pulseLoad(8'h77);
      ss = 1'b0;
      #100;
      cnt0 = valid_cnt;
      spiXfer(1'b0, 1'b0, 1'b0, 8'hF8, 5, 1'b0, 8'h00, got1);
      checkOutput("abort_oe_mid", miso_oe, 1);
      ss = 1'b1;
      #(PERIOD * (SYNC_STAGES + 2));
      checkOutput("abort_oe_off", miso_oe, 0);
      checkOutput("abort_miso_low", miso, 0);
      #100;
      checkOutput("abort_no_valid", valid_cnt - cnt0, 0);
      checkOutput("abort_rx_kept", rx_data, 8'h22);
      v = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h69, 8'hC3, 8'h69, 8'hC3};
      applyStimulus(v, 10);

      // A load while the buffer is full is dropped
      $display("[TB] ignored load");
      setMode(1'b0, 1'b0, 1'b0);
      pulseLoad(8'h4D);
      pulseLoad(8'hB2);
      checkOutput("ign_tx_ready", tx_ready, 0);
      v = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 8'h4D, 8'h99};
      runFrame(v, "ign");

      // Reset in the middle of a frame
      $display("[TB] reset mid-frame");
      setMode(1'b0, 1'b0, 1'b0);
      pulseLoad(8'hF0);
      ss = 1'b0;
      #100;
      pulseLoad(8'h44);
      spiXfer(1'b0, 1'b0, 1'b0, 8'hB7, 3, 1'b0, 8'h00, got1);
      checkOutput("mrst_oe_before", miso_oe, 1);
      checkOutput("mrst_tx_ready_before", tx_ready, 0);
      PRESET = 1'b1;
      #1;
      checkOutput("mrst_miso", miso, 0);
      checkOutput("mrst_miso_oe", miso_oe, 0);
      checkOutput("mrst_tx_ready", tx_ready, 1);
      checkOutput("mrst_rx_data", rx_data, 0);
      checkOutput("mrst_rx_valid", rx_valid, 0);
      checkOutput("mrst_overrun", rx_overrun, 0);
      #(PERIOD - 1);
      PRESET = 1'b0;
      #150;
      checkOutput("mrst_no_restart", miso_oe, 0);
      v = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h3A, 8'hE1, 8'h3A, 8'hE1};
      applyStimulus(v, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
